burst_fault_campaign_ctrl: RTL and testbench
============================================

# burst_fault_campaign_ctrl

Sequencer for automated burst-error fault campaigns on the 12-bit CRC datapath. It steps the burst error injector through every start-address / burst-length combination, holds each fault stable while the downstream CRC checker evaluates the corrupted codeword, and tallies detected, missed and timed-out injections. It sits between the test/control interface and the injector's `fault_start_addr` / `burst_error_length` / `fault_en` inputs; the checker's verdict feeds back into it.

## Interface
- `SETTLE_CYCLES`, 2: cycles each fault is applied before checker results are accepted; legal range 1–15.
- `TIMEOUT_CYCLES`, 16: maximum wait cycles for `chk_valid` per injection; legal range 1–255.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: in IDLE, a high level begins a campaign.
- `abort` in 1: terminates a running campaign.
- `chk_valid` in 1: checker verdict strobe.
- `chk_err_detected` in 1: checker flagged an error; qualified by `chk_valid`.
- `fault_start_addr` out 4: to the injector.
- `burst_error_length` out 2: to the injector; 0 = 1 bit … 3 = 4 bits.
- `fault_en` out 1: to the injector.
- `busy` out 1: campaign in progress.
- `done` out 1: one-cycle pulse when a campaign completes normally.
- `detected_cnt` out 8: injections flagged by the checker.
- `missed_cnt` out 8: injections the checker passed as clean.
- `timeout_cnt` out 8: injections with no verdict inside `TIMEOUT_CYCLES`.

## Operation
- States: IDLE, APPLY, WAIT, NEXT, DONE.
- IDLE: `fault_en`=0, address and length outputs = 0, `busy`=0. When `start`=1, clear all counters, set length = 0 and address = 0, then go to APPLY.
- APPLY: `fault_en`=1. Hold for exactly `SETTLE_CYCLES` cycles, then go to WAIT. `chk_valid` is ignored in this state.
- WAIT: `fault_en`=1, outputs unchanged. The timer starts at 0 on entry.
  - On `chk_valid`=1: increment `detected_cnt` if `chk_err_detected`=1, else increment `missed_cnt`. Go to NEXT.
  - If the timer reaches `TIMEOUT_CYCLES` with no `chk_valid`: increment `timeout_cnt` and go to NEXT.
  - If `chk_valid` arrives in the same cycle as the timeout, it wins: it is counted as a verdict, not a timeout.
- NEXT: one cycle with `fault_en`=0, so the checker sees fault removal. Advance the sweep: address increments first; at its last value it wraps to 0 and the length increments. After the final combination, go to DONE; otherwise go to APPLY.
- Sweep order is length-major: (len 0, addr 0..11), (len 1, addr 0..11), and so on; 48 injections in total.
- DONE: `done`=1 for one cycle, then IDLE. Counters hold until the next accepted `start`.
- Invariant: at DONE, `detected_cnt` + `missed_cnt` + `timeout_cnt` = total injections.
- `abort`=1 in any non-IDLE state: go to IDLE next cycle. `fault_en` drops that cycle, counters are retained, and `done` is not pulsed. `abort` has priority over `chk_valid` and over `start`.
- `start` while busy is ignored.

## Timing
- Reset: the FSM goes to IDLE. All outputs are 0, including every counter, `busy`, `done`, `fault_en`, `fault_start_addr` and `burst_error_length`.
- `start` sampled at edge N: `busy`=1 and `fault_en`=1 from cycle N+1.
- Per-injection cycle count = `SETTLE_CYCLES` + (WAIT cycles up to the verdict, inclusive) + 1.
- `fault_start_addr` and `burst_error_length` change only on the NEXT→APPLY transition. They are stable throughout APPLY and WAIT.
- Counter updates are visible the cycle after the qualifying edge. Counters saturate at 255 and do not wrap.
- `rst` mid-campaign has the same effect as reset: counters are cleared, unlike `abort`.

## Configuration
- `FULL_BURST_ONLY_EN`
  - Defined: for each length L, the address sweeps 0..(12−(L+1)) only, so no truncated bursts are generated. Total is 42 injections (12+11+10+9).
  - Undefined: all 12 addresses for every length, including bursts truncated at bit 11. Total is 48 injections.

## Test plan
- `SETTLE_CYCLES`=2; checker always returns `chk_valid` with `chk_err_detected`=1 one cycle after entering WAIT; pulse `start` → `done` after 48 injections; `detected_cnt`=48, `missed_cnt`=0, `timeout_cnt`=0; sweep order checked cycle-by-cycle.
- Checker never asserts `chk_valid`, `TIMEOUT_CYCLES`=4 → `timeout_cnt`=48, other counts 0, WAIT lasts 4 cycles per injection.
- Checker reports `chk_err_detected`=0 only for length 3 at address 11 → `missed_cnt`=1, `detected_cnt`=47.
- Assert `abort` during WAIT of injection 5 → `fault_en`=0 the next cycle, IDLE, no `done`, counts = 4; a new `start` clears them.
- With `FULL_BURST_ONLY_EN` defined → 42 injections; the last is length 3, address 8; address 9 is never driven with length 3.
- `chk_valid` in the same cycle as the timeout → counted as detected/missed, `timeout_cnt` unchanged; `rst` mid-campaign → all outputs 0 the next cycle.

Source files
------------

// File: rtl/burst_fault_campaign_ctrl.sv
// burst_fault_campaign_ctrl
// Walks the burst error injector through every (length, start address)
// combination, holds each fault for a settle window, waits for the CRC
// checker verdict (or a timeout) and tallies detected / missed / timed-out
// injections in saturating 8-bit counters.
// Optional feature macro: FULL_BURST_ONLY_EN -- when defined, the address
// sweep for length L stops at 11-L so no burst runs past bit 11.
module burst_fault_campaign_ctrl #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       chk_valid,
  input  logic       chk_err_detected,
  output logic [3:0] fault_start_addr,
  output logic [1:0] burst_error_length,
  output logic       fault_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] detected_cnt,
  output logic [7:0] missed_cnt,
  output logic [7:0] timeout_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // Terminal values of the shared settle / timeout timer.
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  logic [3:0] addr_q;
  logic [1:0] len_q;
  logic       fault_en_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] det_q;
  logic [7:0] mis_q;
  logic [7:0] to_q;
  logic [7:0] timer_q;

  logic [3:0] addr_last_d;
  logic [7:0] det_d;
  logic [7:0] mis_d;
  logic [7:0] to_d;

  // Last legal address for the current length, and saturating counter increments.
  always_comb begin
`ifdef FULL_BURST_ONLY_EN
    addr_last_d = 4'd11 - {2'b00, len_q};
`else
    addr_last_d = 4'd11;
`endif
    det_d = (det_q == 8'hFF) ? det_q : det_q + 8'd1;
    mis_d = (mis_q == 8'hFF) ? mis_q : mis_q + 8'd1;
    to_d  = (to_q  == 8'hFF) ? to_q  : to_q  + 8'd1;
  end

  // Campaign FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 4'd0;
      len_q      <= 2'd0;
      fault_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      det_q      <= 8'd0;
      mis_q      <= 8'd0;
      to_q       <= 8'd0;
      timer_q    <= 8'd0;
    end else if (abort && (state_q != S_IDLE)) begin
      // Abort wins over any verdict this cycle; counters are kept for inspection.
      state_q    <= S_IDLE;
      addr_q     <= 4'd0;
      len_q      <= 2'd0;
      fault_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timer_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_APPLY;
            addr_q     <= 4'd0;
            len_q      <= 2'd0;
            fault_en_q <= 1'b1;
            busy_q     <= 1'b1;
            det_q      <= 8'd0;
            mis_q      <= 8'd0;
            to_q       <= 8'd0;
            timer_q    <= 8'd0;
          end
        end
        S_APPLY: begin
          // chk_valid is deliberately ignored while the fault settles.
          if (timer_q == SETTLE_LAST) begin
            state_q <= S_WAIT;
            timer_q <= 8'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_WAIT: begin
          // A verdict on the timeout cycle is still a verdict.
          if (chk_valid) begin
            if (chk_err_detected) begin
              det_q <= det_d;
            end else begin
              mis_q <= mis_d;
            end
            state_q    <= S_NEXT;
            fault_en_q <= 1'b0;
            timer_q    <= 8'd0;
          end else if (timer_q == TIMEOUT_LAST) begin
            to_q       <= to_d;
            state_q    <= S_NEXT;
            fault_en_q <= 1'b0;
            timer_q    <= 8'd0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_NEXT: begin
          // Fault is removed for this one cycle; sweep is length-major.
          timer_q <= 8'd0;
          if (addr_q == addr_last_d) begin
            if (len_q == 2'd3) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_APPLY;
              addr_q     <= 4'd0;
              len_q      <= len_q + 2'd1;
              fault_en_q <= 1'b1;
            end
          end else begin
            state_q    <= S_APPLY;
            addr_q     <= addr_q + 4'd1;
            fault_en_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= 4'd0;
          len_q   <= 2'd0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fault_start_addr   = addr_q;
  assign burst_error_length = len_q;
  assign fault_en           = fault_en_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign detected_cnt       = det_q;
  assign missed_cnt         = mis_q;
  assign timeout_cnt        = to_q;

endmodule

// File: tb/tb_burst_fault_campaign_ctrl.sv
// Testbench for burst_fault_campaign_ctrl: table of whole campaigns with
// a reactive checker model, a queue of expected sweep combinations popped at
// each new injection, plus hand-written abort / reset sequences.
module tb_burst_fault_campaign_ctrl;

  localparam int S = 2;
  localparam int T = 4;
`ifdef FULL_BURST_ONLY_EN
  localparam int N_INJ = 42;
`else
  localparam int N_INJ = 48;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       chk_valid;
  logic       chk_err_detected;
  logic [3:0] fault_start_addr;
  logic [1:0] burst_error_length;
  logic       fault_en;
  logic       busy;
  logic       done;
  logic [7:0] detected_cnt;
  logic [7:0] missed_cnt;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] len;
    logic [3:0] addr;
  } combo_t;

  combo_t exp_q[$];

  typedef struct {
    string name;
    int    mode;   // 0 always detect, 1 never valid, 2 miss on final combination
    int    delay;  // WAIT cycle index at which chk_valid is returned
    int    hold;   // keep start high throughout the campaign
    int    det;
    int    mis;
    int    to;
  } vec_t;

  vec_t vecs[5];

  burst_fault_campaign_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .chk_valid         (chk_valid),
    .chk_err_detected  (chk_err_detected),
    .fault_start_addr  (fault_start_addr),
    .burst_error_length(burst_error_length),
    .fault_en          (fault_en),
    .busy              (busy),
    .done              (done),
    .detected_cnt      (detected_cnt),
    .missed_cnt        (missed_cnt),
    .timeout_cnt       (timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int last_addr(input int l);
`ifdef FULL_BURST_ONLY_EN
    return 11 - l;
`else
    return 11;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(fault_start_addr), 0);
    chk({tag, "_len"}, 32'(burst_error_length), 0);
    chk({tag, "_fault_en"}, 32'(fault_en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_det"}, 32'(detected_cnt), 0);
    chk({tag, "_mis"}, 32'(missed_cnt), 0);
    chk({tag, "_to"}, 32'(timeout_cnt), 0);
  endtask

  task automatic run_campaign(input int mode, input int delay, input int hold_start,
                              input int abort_inj, input int rst_inj,
                              output int n_inj, output bit got_done);
    combo_t e;
    combo_t cur;
    bit     prev_en;
    bit     stop;
    bit     abort_s;
    bit     rst_s;
    int     en_idx;
    int     gap;
    int     exp_len;
    int     inj;
    bit     last_combo;
    exp_q.delete();
    for (int l = 0; l < 4; l++) begin
      for (int a = 0; a <= last_addr(l); a++) begin
        e.len  = 2'(l);
        e.addr = 4'(a);
        exp_q.push_back(e);
      end
    end
    exp_len  = (mode == 1) ? (S + T) : (S + delay + 1);
    prev_en  = 1'b0;
    stop     = 1'b0;
    en_idx   = 0;
    gap      = 0;
    inj      = 0;
    got_done = 1'b0;
    cur      = '0;
    start    = 1'b1;
    for (int cyc = 0; cyc < 1000 && !stop; cyc++) begin
      @(negedge clk);
      abort_s          = abort;
      rst_s            = rst;
      abort            = 1'b0;
      rst              = 1'b0;
      chk_valid        = 1'b0;
      chk_err_detected = 1'b0;
      start            = (hold_start != 0) && !done;
      if (abort_s) begin
        chk("abort_fault_en", 32'(fault_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        stop = 1'b1;
      end else if (rst_s) begin
        check_all_zero("midrst");
        stop = 1'b1;
      end else begin
        if (fault_en && !prev_en) begin
          inj++;
          en_idx = 0;
          if (inj > 1) chk("next_gap", 32'(gap), 1);
          chk("busy_at_inj", 32'(busy), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_injection actual=%0d required=%0d", inj, N_INJ);
          end else begin
            cur = exp_q.pop_front();
            chk("sweep_len", 32'(burst_error_length), 32'(cur.len));
            chk("sweep_addr", 32'(fault_start_addr), 32'(cur.addr));
          end
          $display("inj %0d len %0d addr %0d", inj, burst_error_length, fault_start_addr);
        end else if (fault_en) begin
          en_idx++;
          chk("hold_len", 32'(burst_error_length), 32'(cur.len));
          chk("hold_addr", 32'(fault_start_addr), 32'(cur.addr));
        end else if (prev_en) begin
          chk("fault_len_cycles", 32'(en_idx + 1), 32'(exp_len));
          gap = 1;
        end else begin
          gap++;
        end
        if (done) begin
          got_done = 1'b1;
          chk("done_inj_count", 32'(inj), 32'(N_INJ));
          chk("done_queue_empty", 32'(exp_q.size()), 0);
          chk("done_fault_en", 32'(fault_en), 0);
          stop = 1'b1;
        end
        if (fault_en && abort_inj == inj && en_idx == S) abort = 1'b1;
        if (fault_en && rst_inj == inj && en_idx == S) rst = 1'b1;
        last_combo = (cur.len == 2'd3) && (32'(cur.addr) == 32'(last_addr(3)));
        if (fault_en && mode != 1 && en_idx == S + delay) begin
          chk_valid        = 1'b1;
          chk_err_detected = !(mode == 2 && last_combo);
        end
      end
      prev_en = fault_en;
    end
    start = 1'b0;
    n_inj = inj;
    if (!stop) begin
      checks++;
      errors++;
      $display("FAIL campaign_timeout actual=%0d required=%0d", inj, N_INJ);
    end
  endtask

  initial begin
    int n;
    bit gd;
    bit any_done;

    vecs[0] = '{name: "all_detect",  mode: 0, delay: 1, hold: 0, det: N_INJ,     mis: 0, to: 0};
    vecs[1] = '{name: "all_timeout", mode: 1, delay: 0, hold: 0, det: 0,         mis: 0, to: N_INJ};
    vecs[2] = '{name: "one_miss",    mode: 2, delay: 1, hold: 0, det: N_INJ - 1, mis: 1, to: 0};
    vecs[3] = '{name: "valid_at_to", mode: 0, delay: T - 1, hold: 1, det: N_INJ, mis: 0, to: 0};
    vecs[4] = '{name: "miss_first",  mode: 2, delay: 0, hold: 0, det: N_INJ - 1, mis: 1, to: 0};

    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    chk_valid        = 1'b0;
    chk_err_detected = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int v = 0; v < 5; v++) begin
      run_campaign(vecs[v].mode, vecs[v].delay, vecs[v].hold, 0, 0, n, gd);
      chk({vecs[v].name, "_done"}, 32'(gd), 1);
      chk({vecs[v].name, "_det"}, 32'(detected_cnt), 32'(vecs[v].det));
      chk({vecs[v].name, "_mis"}, 32'(missed_cnt), 32'(vecs[v].mis));
      chk({vecs[v].name, "_to"}, 32'(timeout_cnt), 32'(vecs[v].to));
      @(negedge clk);
      chk({vecs[v].name, "_done_pulse"}, 32'(done), 0);
      chk({vecs[v].name, "_busy_after"}, 32'(busy), 0);
      chk({vecs[v].name, "_addr_after"}, 32'(fault_start_addr), 0);
      chk({vecs[v].name, "_len_after"}, 32'(burst_error_length), 0);
      chk({vecs[v].name, "_det_hold"}, 32'(detected_cnt), 32'(vecs[v].det));
      $display("campaign %s inj %0d det %0d mis %0d to %0d", vecs[v].name, n,
               detected_cnt, missed_cnt, timeout_cnt);
    end

    // Abort in the first WAIT cycle of injection 5, with a verdict on the same cycle.
    run_campaign(0, 0, 0, 5, 0, n, gd);
    chk("abort_no_done", 32'(gd), 0);
    chk("abort_inj", 32'(n), 5);
    chk("abort_det", 32'(detected_cnt), 4);
    chk("abort_mis", 32'(missed_cnt), 0);
    chk("abort_to", 32'(timeout_cnt), 0);
    any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_done |= done;
    end
    chk("abort_idle_done", 32'(any_done), 0);
    chk("abort_idle_fault_en", 32'(fault_en), 0);
    chk("abort_det_hold", 32'(detected_cnt), 4);
    $display("abort inj %0d det %0d", n, detected_cnt);

    // A new start clears the retained counts.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_det", 32'(detected_cnt), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_fault_en", 32'(fault_en), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort2_fault_en", 32'(fault_en), 0);
    chk("abort2_busy", 32'(busy), 0);
    $display("restart then abort det %0d busy %0d", detected_cnt, busy);

    // Reset mid-campaign clears everything, unlike abort.
    run_campaign(0, 1, 0, 0, 7, n, gd);
    chk("midrst_no_done", 32'(gd), 0);
    @(negedge clk);
    check_all_zero("post_midrst");
    $display("midrst inj %0d det %0d", n, detected_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
